// File: rtl/servo_update_sched_pkg.sv
// Shared state encoding and default constants for the
// gimbal servo update scheduler.
package servo_update_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_X    = 2'd1,
    S_Y    = 2'd2
  } state_t;

  localparam int THR_W        = 15;
  localparam int CLK_DIV_D    = 50;
  localparam int PERIOD_US_D  = 20000;
  localparam int THR_MIN_D    = 500;
  localparam int THR_MAX_D    = 2500;
  localparam int THR_CENTRE_D = 1500;
  localparam int SLEW_MAX_D   = 40;
  localparam int LOST_D       = 30;

  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/servo_update_sched_if.sv
// Setpoint request / servo output bundle between the
// per-axis setpoint generators and the scheduler.
interface servo_update_sched_if;
  import servo_update_sched_pkg::*;

  logic             Move_EN;
  logic             vsync_in;
  logic [THR_W-1:0] req_x_thr;
  logic [THR_W-1:0] req_y_thr;
  logic             lost_x;
  logic             lost_y;
  logic [THR_W-1:0] pwm_thresh_x;
  logic [THR_W-1:0] pwm_thresh_y;
  logic             period_start;
  logic             pwm_x;
  logic             pwm_y;

  modport master (
    output Move_EN, vsync_in,
    output req_x_thr, req_y_thr,
    output lost_x, lost_y,
    input  pwm_thresh_x, pwm_thresh_y,
    input  period_start, pwm_x, pwm_y
  );

  modport slave (
    input  Move_EN, vsync_in,
    input  req_x_thr, req_y_thr,
    input  lost_x, lost_y,
    output pwm_thresh_x, pwm_thresh_y,
    output period_start, pwm_x, pwm_y
  );

endinterface

// File: rtl/servo_axis_step.sv
// One axis: lost-frame counter plus recentre, clamp and
// slew limiting of the requested pulse width.
module servo_axis_step
  import servo_update_sched_pkg::*;
#(
  parameter int THR_MIN     = THR_MIN_D,
  parameter int THR_MAX     = THR_MAX_D,
  parameter int THR_CENTRE  = THR_CENTRE_D,
  parameter int SLEW_MAX    = SLEW_MAX_D,
  parameter int LOST_FRAMES = LOST_D
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic             i_lost,
  input  logic [THR_W-1:0] i_req,
  input  logic [15:0]      i_shadow,
  output logic [15:0]      o_next
);

  localparam int LC_W = cw(LOST_FRAMES + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOST_FRAMES);
  localparam logic [15:0] MIN16  = 16'(THR_MIN);
  localparam logic [15:0] MAX16  = 16'(THR_MAX);
  localparam logic [15:0] CTR16  = 16'(THR_CENTRE);
  localparam logic [15:0] SLEW16 = 16'(SLEW_MAX);

  logic [LC_W-1:0] r_lost_cnt;
  logic [LC_W-1:0] w_lost_nxt;
  logic [15:0]     w_tgt;
  logic [15:0]     w_clp;
  logic [15:0]     w_res;

  always_comb begin
    w_lost_nxt = '0;
    if (i_lost)
      w_lost_nxt = (r_lost_cnt == LC_MAX) ?
                   LC_MAX : r_lost_cnt + 1'b1;
  end

  always_comb begin
    w_tgt = {1'b0, i_req};
    if (w_lost_nxt == LC_MAX)
      w_tgt = CTR16;
    else if (i_lost)
      w_tgt = i_shadow;
    w_clp = w_tgt;
    if (w_tgt < MIN16)
      w_clp = MIN16;
    else if (w_tgt > MAX16)
      w_clp = MAX16;
    w_res = w_clp;
    if (w_clp > i_shadow + SLEW16)
      w_res = i_shadow + SLEW16;
    else if (w_clp + SLEW16 < i_shadow)
      w_res = i_shadow - SLEW16;
  end

  assign o_next = w_res;

  always_ff @(posedge clk) begin
    if (!i_rst_n)
      r_lost_cnt <= '0;
    else if (i_step)
      r_lost_cnt <= w_lost_nxt;
  end

endmodule

// File: rtl/servo_update_sched.sv
// Per-frame X/Y servo setpoint scheduler with shared 1 us
// timebase and period-boundary commit of PWM thresholds.
module servo_update_sched
  import servo_update_sched_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_D,
  parameter int PERIOD_US   = PERIOD_US_D,
  parameter int THR_MIN     = THR_MIN_D,
  parameter int THR_MAX     = THR_MAX_D,
  parameter int THR_CENTRE  = THR_CENTRE_D,
  parameter int SLEW_MAX    = SLEW_MAX_D,
  parameter int LOST_FRAMES = LOST_D
) (
  input  logic                clk_50M,
  input  logic                reset,
  servo_update_sched_if.slave bus
);

  localparam int DW = cw(CLK_DIV);
  localparam int UW = cw(PERIOD_US);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [UW-1:0] US_LAST  = UW'(PERIOD_US - 1);
  localparam logic [15:0]   CTR16    = 16'(THR_CENTRE);

  logic [DW-1:0] r_div;
  logic [UW-1:0] r_us;
  logic          r_ps;
  logic          r_pwm_x;
  logic          r_pwm_y;
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_sh_x;
  logic [15:0]   r_sh_y;
  logic [15:0]   r_act_x;
  logic [15:0]   r_act_y;
  logic [15:0]   w_nx_x;
  logic [15:0]   w_nx_y;
  logic [15:0]   w_us16;
  logic          w_tick;
  logic          w_wrap;
  logic          w_evt;
  logic          w_step_x;
  logic          w_step_y;

  assign w_tick = (r_div == DIV_LAST);
  assign w_wrap = w_tick && (r_us == US_LAST);
  assign w_evt  = r_s2 & ~r_s3;
  assign w_us16 = 16'(r_us);

  // Active thresholds only move in the cycle after the wrap,
  // so a pulse in flight never sees a new value.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      r_div   <= '0;
      r_us    <= '0;
      r_ps    <= 1'b0;
      r_pwm_x <= 1'b0;
      r_pwm_y <= 1'b0;
      r_act_x <= CTR16;
      r_act_y <= CTR16;
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick)
        r_us  <= w_wrap ? '0 : r_us + 1'b1;
      r_ps    <= w_wrap;
      r_pwm_x <= bus.Move_EN && (w_us16 < r_act_x);
      r_pwm_y <= bus.Move_EN && (w_us16 < r_act_y);
      if (r_ps) begin
        r_act_x <= r_sh_x;
        r_act_y <= r_sh_y;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_state <= S_IDLE;
      r_sh_x  <= CTR16;
      r_sh_y  <= CTR16;
    end else begin
      r_s1    <= bus.vsync_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_state <= w_state_nxt;
      if (w_step_x)
        r_sh_x <= w_nx_x;
      if (w_step_y)
        r_sh_y <= w_nx_y;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_x    = 1'b0;
    w_step_y    = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_evt) w_state_nxt = S_X;
      S_X: begin
        w_state_nxt = S_Y;
        w_step_x    = bus.Move_EN;
      end
      S_Y: begin
        w_state_nxt = S_IDLE;
        w_step_y    = bus.Move_EN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  servo_axis_step #(
    .THR_MIN(THR_MIN), .THR_MAX(THR_MAX),
    .THR_CENTRE(THR_CENTRE), .SLEW_MAX(SLEW_MAX),
    .LOST_FRAMES(LOST_FRAMES)
  ) u_ax_x (
    .clk(clk_50M), .i_rst_n(reset),
    .i_step(w_step_x), .i_lost(bus.lost_x),
    .i_req(bus.req_x_thr), .i_shadow(r_sh_x),
    .o_next(w_nx_x)
  );

  servo_axis_step #(
    .THR_MIN(THR_MIN), .THR_MAX(THR_MAX),
    .THR_CENTRE(THR_CENTRE), .SLEW_MAX(SLEW_MAX),
    .LOST_FRAMES(LOST_FRAMES)
  ) u_ax_y (
    .clk(clk_50M), .i_rst_n(reset),
    .i_step(w_step_y), .i_lost(bus.lost_y),
    .i_req(bus.req_y_thr), .i_shadow(r_sh_y),
    .o_next(w_nx_y)
  );

  assign bus.pwm_thresh_x = r_act_x[THR_W-1:0];
  assign bus.pwm_thresh_y = r_act_y[THR_W-1:0];
  assign bus.period_start = r_ps;
  assign bus.pwm_x        = r_pwm_x;
  assign bus.pwm_y        = r_pwm_y;

endmodule
